// File: rtl/gf180mcu_fd_sc_mcu9t5v0__polarity_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__polarity_pkg.sv - shared types and constants for the polarity-detecting frame receiver
package gf180mcu_fd_sc_mcu9t5v0__polarity_pkg;

    localparam int SYNC_W = 8;
    localparam int MISS_W = 3;
    localparam logic [SYNC_W-1:0] DEFAULT_SYNC = 8'hB4;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync2.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__sync2.sv - two-flop synchronizer for the serial line
module gf180mcu_fd_sc_mcu9t5v0__sync2 (
    input  logic CLK,
    input  logic RN,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__polarity_rx.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__polarity_rx.sv - serial frame receiver with sync search, line polarity detection and lock tracking
module gf180mcu_fd_sc_mcu9t5v0__polarity_rx
    import gf180mcu_fd_sc_mcu9t5v0__polarity_pkg::*;
#(
    parameter logic [SYNC_W-1:0] SYNC_WORD   = DEFAULT_SYNC,
    parameter int                PAYLOAD_LEN = 16,
    parameter int                MISS_MAX    = 2
) (
    input  logic CLK,
    input  logic RN,
    input  logic I,
    output logic Z,
    output logic VALID,
    output logic INV,
    output logic LOCK,
    inout  wire  VDD,
    inout  wire  VSS
);

    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [2:0]        CHK_LAST  = 3'(SYNC_W - 1);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_MAX);

    // An all-zero or all-one sync word is indistinguishable from an idle line in either polarity.
    if (SYNC_WORD == '0 || SYNC_WORD == '1) begin : g_bad_sync
        $error("SYNC_WORD must not be all zeros or all ones");
    end
    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 255 || MISS_MAX < 1 || MISS_MAX > 7) begin : g_bad_range
        $error("PAYLOAD_LEN or MISS_MAX out of range");
    end

    wire unused_supply = VDD ^ VSS;

    logic              i_sync;
    logic [SYNC_W-1:0] w;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [2:0]        chk_cnt, chk_cnt_nx;
    logic [MISS_W-1:0] miss, miss_nx, miss_inc;
    logic              z_nx, valid_nx, inv_nx, lock_nx;
    logic              sync_hit, sync_hit_inv, chk_good, chk_last;

    gf180mcu_fd_sc_mcu9t5v0__sync2 u_sync (
        .CLK (CLK),
        .RN  (RN),
        .D   (I),
        .Q   (i_sync)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) w <= '0;
        else     w <= {w[SYNC_W-2:0], i_sync};
    end

    assign sync_hit     = (w == SYNC_WORD);
    assign sync_hit_inv = (w == ~SYNC_WORD);
    // Re-checks use the polarity found at lock time, so an opposite-polarity word is a miss.
    assign chk_good     = ((w ^ {SYNC_W{INV}}) == SYNC_WORD);
    assign miss_inc     = chk_good ? '0 : miss + 1'b1;
    assign chk_last     = (chk_cnt == CHK_LAST);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) state <= ST_SEARCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_SEARCH:  if (sync_hit || sync_hit_inv) state_nx = ST_PAYLOAD;
            ST_PAYLOAD: if (bit_cnt == LAST_BIT)      state_nx = ST_CHECK;
            ST_CHECK:   if (chk_last) state_nx = (miss_inc == MISS_LIM) ? ST_SEARCH : ST_PAYLOAD;
            default:    state_nx = ST_SEARCH;
        endcase
    end

    always_comb begin
        bit_cnt_nx = bit_cnt;
        chk_cnt_nx = chk_cnt;
        miss_nx    = miss;
        z_nx       = Z;
        valid_nx   = 1'b0;
        inv_nx     = INV;
        lock_nx    = LOCK;
        case (state)
            ST_SEARCH: begin
                if (sync_hit || sync_hit_inv) begin
                    inv_nx  = sync_hit_inv;
                    lock_nx = 1'b1;
                    miss_nx = '0;
                end
            end
            ST_PAYLOAD: begin
                z_nx       = w[0] ^ INV;
                valid_nx   = 1'b1;
                bit_cnt_nx = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            ST_CHECK: begin
                chk_cnt_nx = chk_cnt + 1'b1;
                if (chk_last) begin
                    if (miss_inc == MISS_LIM) begin
                        miss_nx = '0;
                        lock_nx = 1'b0;
                    end else begin
                        miss_nx = miss_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            bit_cnt <= '0;
            chk_cnt <= '0;
            miss    <= '0;
            Z       <= 1'b0;
            VALID   <= 1'b0;
            INV     <= 1'b0;
            LOCK    <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt_nx;
            chk_cnt <= chk_cnt_nx;
            miss    <= miss_nx;
            Z       <= z_nx;
            VALID   <= valid_nx;
            INV     <= inv_nx;
            LOCK    <= lock_nx;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__polarity_rx.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__polarity_rx.sv - scoreboard bench for the polarity-detecting frame receiver
module tb_gf180mcu_fd_sc_mcu9t5v0__polarity_rx;

    localparam logic [7:0] SW   = 8'hB4;
    localparam int         L    = 16;
    localparam int         MM   = 2;
    localparam int         MAXB = 2048;

    logic CLK = 1'b0;
    logic RN  = 1'b0;
    logic I   = 1'b0;
    logic Z, VALID, INV, LOCK;
    wire  vdd = 1'b1;
    wire  vss = 1'b0;

    gf180mcu_fd_sc_mcu9t5v0__polarity_rx #(
        .SYNC_WORD   (SW),
        .PAYLOAD_LEN (L),
        .MISS_MAX    (MM)
    ) dut (
        .CLK   (CLK),
        .RN    (RN),
        .I     (I),
        .Z     (Z),
        .VALID (VALID),
        .INV   (INV),
        .LOCK  (LOCK),
        .VDD   (vdd),
        .VSS   (vss)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   e;
        logic z;
    } exp_t;

    exp_t sbq[$];
    logic b[MAXB];
    logic exp_lock[MAXB], exp_inv[MAXB], exp_valid[MAXB], exp_z[MAXB];
    int   bn;
    int   edge_cnt;
    int   cur_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    always @(posedge CLK or negedge RN) begin
        if (!RN) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Bits presented before reset release are seen as zeros (flops cleared).
    function automatic logic [7:0] word_at(input int j);
        logic [7:0] w;
        for (int m = 0; m < 8; m++) w[7-m] = (j - 7 + m >= 1) ? b[j-7+m] : 1'b0;
        return w;
    endfunction

    task automatic put(input logic [31:0] v, input int width);
        for (int i = width - 1; i >= 0; i--) begin
            bn++;
            b[bn] = v[i];
        end
    endtask

    task automatic put_rand(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bn++;
            b[bn] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_li(input int from, input int n, input logic lk, input logic iv);
        for (int x = from; x <= n; x++) begin
            exp_lock[x] = lk;
            exp_inv[x]  = iv;
        end
    endtask

    // Frame-level reference: bit j is last bit of a window; its decision lands on edge j+3.
    task automatic run_model(input int n);
        int j, e, miss;
        logic inv, zb, done;
        logic [7:0] w;
        exp_t item;
        for (int x = 0; x <= n; x++) begin
            exp_lock[x] = 0; exp_inv[x] = 0; exp_valid[x] = 0; exp_z[x] = 0;
        end
        sbq.delete();
        j = 1; inv = 0; done = 0;
        while (!done && j + 3 <= n) begin
            w = word_at(j);
            if (w == SW || w == ~SW) begin
                inv  = (w != SW);
                miss = 0;
                set_li(j + 3, n, 1'b1, inv);
                while (1) begin
                    for (int i = 1; i <= L; i++) begin
                        e = j + i + 3;
                        if (e <= n) begin
                            zb = b[j+i] ^ inv;
                            exp_valid[e] = 1'b1;
                            for (int x = e; x <= n; x++) exp_z[x] = zb;
                            item.e = e;
                            item.z = zb;
                            sbq.push_back(item);
                        end
                    end
                    j = j + L + 8;
                    e = j + 3;
                    if (e > n) begin
                        done = 1;
                        break;
                    end
                    if ((word_at(j) ^ {8{inv}}) == SW) miss = 0;
                    else                               miss++;
                    if (miss == MM) begin
                        set_li(e, n, 1'b0, inv);
                        break;
                    end
                end
            end
            j++;
        end
    endtask

    always @(negedge CLK) begin
        exp_t item;
        if (RN && edge_cnt > 0 && edge_cnt <= cur_n) begin
            chk("lock",  LOCK,  exp_lock[edge_cnt]);
            chk("inv",   INV,   exp_inv[edge_cnt]);
            chk("valid", VALID, exp_valid[edge_cnt]);
            chk("z_hold", Z,    exp_z[edge_cnt]);
            if (VALID) begin
                chk("sb_avail", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    item = sbq.pop_front();
                    chk("z_edge", edge_cnt, item.e);
                    chk("z_bit",  Z,        item.z);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_z",     Z,     0);
        chk("rst_valid", VALID, 0);
        chk("rst_inv",   INV,   0);
        chk("rst_lock",  LOCK,  0);
    endtask

    task automatic run_seg();
        int n;
        n = bn;
        cur_n = n;
        run_model(n);
        @(negedge CLK);
        RN = 1'b1;
        I  = b[1];
        for (int k = 2; k <= n; k++) begin
            @(negedge CLK);
            I = b[k];
        end
        @(negedge CLK);
        #2;
        chk("sb_drained", sbq.size(), 0);
        RN = 1'b0;
        #1;
        check_reset_outputs();
        bn = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bn = 0;
        repeat (2) @(negedge CLK);
        check_reset_outputs();

        // Normal frame, bad-sync recovery, opposite-polarity miss, then loss of lock.
        put(0, 12);
        put(8'hB4, 8); put(16'hC3A5, 16);
        put(8'hB4, 8); put_rand(16);
        put(8'hB5, 8); put_rand(16);
        put(8'hB4, 8); put_rand(16);
        put(8'h4B, 8); put_rand(16);
        put(8'hB4, 8); put_rand(16);
        put(8'h00, 8); put_rand(16);
        put(8'h00, 8); put_rand(16);
        put(8'hB4, 8);
        put_rand(30);
        run_seg();

        // Fully inverted line.
        put(0, 5);
        put(8'h4B, 8); put(16'h3C5A, 16);
        put(8'h4B, 8); put_rand(16);
        for (int f = 0; f < 3; f++) begin
            put_rand(8); put_rand(16);
        end
        run_seg();

        // Reset lands on payload bit 7; the remainder must not relock by itself.
        put(0, 10);
        put(8'hB4, 8); put(8'hC3, 8);
        run_seg();
        put(8'hA5, 8);
        put(8'hB4, 8); put(16'hC3A5, 16);
        put(8'hB4, 8); put_rand(16);
        put_rand(10);
        run_seg();

        // Random mix of good, inverted and corrupt syncs with slips.
        for (int s = 0; s < 2; s++) begin
            put_rand(6);
            for (int f = 0; f < 12; f++) begin
                case ($urandom_range(0, 3))
                    0, 1:    put(8'hB4, 8);
                    2:       put(8'h4B, 8);
                    default: put_rand(8);
                endcase
                put_rand(16);
                if ($urandom_range(0, 4) == 0) put_rand($urandom_range(1, 5));
            end
            run_seg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
